// File: rtl/thermal_alarm_fsm.sv
// Thermal/alarm sequencer: hysteretic heat drive, debounced emergency button,
// over-temperature trip, latched alarm with acknowledge, timed cooldown, alarm counter.
//
// state    | meaning
// IDLE     | no drive, waiting for temp >= thr_on or a trip
// ACTIVE   | drive follows temp until it falls below thr_off
// ALARM    | latched alarm; leaves only on ack with the button released
// COOLDOWN | quiet hold of HOLD_CYCLES cycles before returning to IDLE
module thermal_alarm_fsm #(
    parameter int TEMP_W      = 4,
    parameter int DEB_CYCLES  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bt,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] thr_on,
    input  logic [TEMP_W-1:0] thr_off,
    input  logic              ack,
    output logic [TEMP_W:0]   E,
    output logic [1:0]        state_o,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  alarm_cnt
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ALARM    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [DEB_W-1:0]    deb_cnt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                bt_db, ovt, trip;

    assign bt_db   = (deb_cnt == DEB_MAX);
    assign ovt     = &temp;
    assign trip    = bt_db | ovt;
    assign cfg_err = (thr_off > thr_on);
    assign state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            alarm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (!bt)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + DEB_W'(1);
            if (state_nxt == ALARM && state != ALARM && alarm_cnt != '1)
                alarm_cnt <= alarm_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        case (state)
            IDLE: begin
                if (trip)
                    state_nxt = ALARM;
                else if (!cfg_err && temp >= thr_on)
                    state_nxt = ACTIVE;
                else
                    state_nxt = IDLE;
            end
            ACTIVE: begin
                if (trip)
                    state_nxt = ALARM;
                else if (cfg_err || temp < thr_off)
                    state_nxt = IDLE;
                else
                    state_nxt = ACTIVE;
            end
            ALARM: begin
                // A held button blocks the acknowledge so the alarm cannot be dismissed mid-press.
                if (ack && !bt_db) begin
                    state_nxt = COOLDOWN;
                    hold_nxt  = HOLD_MAX;
                end else begin
                    state_nxt = ALARM;
                end
            end
            COOLDOWN: begin
                if (trip) begin
                    state_nxt = ALARM;
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = COOLDOWN;
                    hold_nxt  = hold_cnt - HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        E = '0;
        case (state)
            ACTIVE:  E = {1'b0, temp};
            ALARM:   E = {1'b1, {TEMP_W{1'b0}}};
            default: E = '0;
        endcase
    end

endmodule

// File: tb/tb_thermal_alarm_fsm.sv
// Directed bench for thermal_alarm_fsm: vector table for the main sequence,
// hand-written sequences for counter saturation and asynchronous reset.
module tb_thermal_alarm_fsm;

    logic       clk, reset, bt, ack;
    logic [3:0] temp, thr_on, thr_off;
    logic [4:0] E;
    logic [1:0] state_o;
    logic       cfg_err;
    logic [3:0] alarm_cnt;

    int checks   = 0;
    int failures = 0;

    thermal_alarm_fsm #(.TEMP_W(4), .DEB_CYCLES(3), .HOLD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bt(bt), .temp(temp), .thr_on(thr_on),
        .thr_off(thr_off), .ack(ack), .E(E), .state_o(state_o),
        .cfg_err(cfg_err), .alarm_cnt(alarm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       bt;
        logic [3:0] temp;
        logic [3:0] thr_on;
        logic [3:0] thr_off;
        logic       ack;
        logic [1:0] st;
        logic [4:0] e;
        logic [3:0] cnt;
        logic       cfg;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic b, input logic [3:0] t, input logic [3:0] on,
                       input logic [3:0] off, input logic a, input logic [1:0] st,
                       input logic [4:0] e, input logic [3:0] cnt, input logic cfg);
        vec_t v;
        v.bt = b; v.temp = t; v.thr_on = on; v.thr_off = off; v.ack = a;
        v.st = st; v.e = e; v.cnt = cnt; v.cfg = cfg;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] st,
                           input logic [4:0] e, input logic [3:0] cnt);
        chk({tag, "_state"}, idx, 32'(state_o), 32'(st));
        chk({tag, "_E"}, idx, 32'(E), 32'(e));
        chk({tag, "_cnt"}, idx, 32'(alarm_cnt), 32'(cnt));
    endtask

    localparam logic [1:0] S_IDLE = 2'd0, S_ACT = 2'd1, S_ALM = 2'd2, S_COOL = 2'd3;

    initial begin
        logic [3:0] exp_cnt;
        reset = 1'b1; bt = 1'b0; ack = 1'b0; temp = 4'd0; thr_on = 4'd8; thr_off = 4'd5;

        // bt, temp, on, off, ack | state, E, cnt, cfg_err
        add(0, 7, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(0, 8, 8, 5, 0, S_ACT,  5'h08, 0, 0);
        add(0,10, 8, 5, 0, S_ACT,  5'h0A, 0, 0);
        add(0, 6, 8, 5, 0, S_ACT,  5'h06, 0, 0);
        add(0, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(0, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_IDLE, 5'h00, 0, 0);
        add(1, 4, 8, 5, 0, S_ALM,  5'h10, 1, 0);
        add(1, 4, 8, 5, 0, S_ALM,  5'h10, 1, 0);
        add(1, 4, 8, 5, 1, S_ALM,  5'h10, 1, 0);
        add(0, 4, 8, 5, 0, S_ALM,  5'h10, 1, 0);
        add(0, 4, 8, 5, 1, S_COOL, 5'h00, 1, 0);
        add(0, 9, 8, 5, 0, S_COOL, 5'h00, 1, 0);
        add(0, 9, 8, 5, 0, S_COOL, 5'h00, 1, 0);
        add(0, 9, 8, 5, 0, S_COOL, 5'h00, 1, 0);
        add(0, 9, 8, 5, 0, S_IDLE, 5'h00, 1, 0);
        add(0, 9, 8, 5, 0, S_ACT,  5'h09, 1, 0);
        add(0,12, 8, 5, 0, S_ACT,  5'h0C, 1, 0);
        add(0,15, 8, 5, 0, S_ALM,  5'h10, 2, 0);
        add(0,15, 8, 5, 0, S_ALM,  5'h10, 2, 0);
        add(0, 3, 8, 5, 1, S_COOL, 5'h00, 2, 0);
        add(0,15, 8, 5, 0, S_ALM,  5'h10, 3, 0);
        add(0, 3, 8, 5, 1, S_COOL, 5'h00, 3, 0);
        add(0, 3, 8, 5, 0, S_COOL, 5'h00, 3, 0);
        add(0, 3, 8, 5, 0, S_COOL, 5'h00, 3, 0);
        add(0, 3, 8, 5, 0, S_COOL, 5'h00, 3, 0);
        add(0, 3, 8, 5, 0, S_IDLE, 5'h00, 3, 0);
        add(0,12, 8, 9, 0, S_IDLE, 5'h00, 3, 1);
        add(0,12, 8, 9, 0, S_IDLE, 5'h00, 3, 1);
        add(0,12, 8, 5, 0, S_ACT,  5'h0C, 3, 0);
        add(0,12, 8, 9, 0, S_IDLE, 5'h00, 3, 1);
        add(0,12, 8, 5, 0, S_ACT,  5'h0C, 3, 0);
        add(0, 7, 7, 7, 0, S_ACT,  5'h07, 3, 0);
        add(0, 6, 7, 7, 0, S_IDLE, 5'h00, 3, 0);

        #1;
        chk_all("reset_hold", 0, S_IDLE, 5'h00, 4'd0);
        step();
        step();
        chk_all("reset_edge", 0, S_IDLE, 5'h00, 4'd0);
        reset = 1'b0;

        foreach (vq[i]) begin
            bt = vq[i].bt; temp = vq[i].temp; thr_on = vq[i].thr_on;
            thr_off = vq[i].thr_off; ack = vq[i].ack;
            step();
            chk_all("vec", i, vq[i].st, vq[i].e, vq[i].cnt);
            chk("vec_cfg_err", i, 32'(cfg_err), 32'(vq[i].cfg));
        end

        // Repeated alarm entries drive the counter past its maximum.
        thr_on = 4'd8; thr_off = 4'd5; bt = 1'b0;
        exp_cnt = 4'd3;
        for (int k = 0; k < 14; k++) begin
            temp = 4'd15; ack = 1'b0;
            step();
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            chk_all("sat_alarm", k, S_ALM, 5'h10, exp_cnt);
            temp = 4'd0; ack = 1'b1;
            step();
            chk_all("sat_cool", k, S_COOL, 5'h00, exp_cnt);
        end
        ack = 1'b0;
        step();
        chk_all("pre_reset_cool", 0, S_COOL, 5'h00, 4'd15);

        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 0, S_IDLE, 5'h00, 4'd0);
        #3;
        reset = 1'b0;
        temp = 4'd9;
        step();
        chk_all("post_reset", 0, S_ACT, 5'h09, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/thermal_alarm_fsm.md
Name: thermal_alarm_fsm

Overview:
- Parametrised thermal/alarm controller FSM. Generalises the 3-state heat/alarm controller to a configurable temperature width.
- Adds a debounced emergency button, programmable hysteresis thresholds, over-temperature detection and a latched alarm with acknowledge and timed cooldown.
- Adds a saturating alarm-event counter.
- Sits between the sensor/button input conditioning and the actuator/LED driver.

Parameters:
TEMP_W, 4, width of temp, thresholds and drive field
DEB_CYCLES, 3, consecutive high samples of bt required to assert the internal debounced button (>=1)
HOLD_CYCLES, 4, cycles spent in COOLDOWN before returning to IDLE (>=1)
CNT_W, 4, width of the alarm event counter

Ports:
clk  in  1  clock
reset  in  1  reset
bt  in  1  raw emergency button, synchronous to clk
temp  in  TEMP_W  current temperature code
thr_on  in  TEMP_W  activation threshold
thr_off  in  TEMP_W  deactivation threshold
ack  in  1  alarm acknowledge
E  out  TEMP_W+1  {alarm bit, drive[TEMP_W-1:0]}
state_o  out  2  current state: 0 IDLE, 1 ACTIVE, 2 ALARM, 3 COOLDOWN
cfg_err  out  1  thr_off > thr_on (combinational)
alarm_cnt  out  CNT_W  number of entries into ALARM, saturating

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: state IDLE, debounce counter 0, hold counter 0, alarm_cnt 0. Therefore E=0 and state_o=0 during and after reset.
- Reset asserted mid-operation, including in ALARM or COOLDOWN, forces IDLE immediately.
- Debounce counter:
  - bt=1: increments, saturating at DEB_CYCLES.
  - bt=0: clears to 0.
  - bt_db = (counter == DEB_CYCLES).
  - Release is immediate.
  - Latency: bt sampled high on DEB_CYCLES consecutive edges asserts bt_db; the state enters ALARM on the next edge, DEB_CYCLES+1 edges after the first high sample.
- ovt = (temp == all ones).
- trip = bt_db | ovt. trip has highest priority in IDLE, ACTIVE and COOLDOWN.
- IDLE:
  - trip -> ALARM.
  - Else if !cfg_err and temp >= thr_on -> ACTIVE.
  - Else stay.
- ACTIVE:
  - trip -> ALARM.
  - Else if cfg_err or temp < thr_off -> IDLE.
  - Else stay (hysteresis band thr_off..thr_on holds ACTIVE).
- ALARM:
  - Latched; temp and trip are ignored.
  - ack=1 and bt_db=0 -> COOLDOWN, with the hold counter loaded to HOLD_CYCLES.
  - ack while bt_db=1 is ignored.
  - A level-held ack is not required beyond that one edge.
- COOLDOWN:
  - trip -> ALARM.
  - Else the hold counter decrements each cycle. When it is 1, the next state is IDLE, so COOLDOWN lasts exactly HOLD_CYCLES cycles.
  - temp >= thr_on does not activate during COOLDOWN.
- Output decode (combinational from state register and temp):
  - IDLE: E=0.
  - ACTIVE: E={1'b0,temp}.
  - ALARM: E={1'b1,{TEMP_W{1'b0}}}.
  - COOLDOWN: E=0.
- alarm_cnt:
  - Increments on every edge where state transitions into ALARM from a non-ALARM state.
  - No increment while remaining in ALARM.
  - Saturates at 2^CNT_W-1.
- Thresholds are sampled every cycle; no latching.
- thr_on == thr_off is legal (no hysteresis); cfg_err=0.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
(All scenarios: TEMP_W=4, DEB=3, HOLD=4, CNT_W=4, thr_on=8, thr_off=5.)
1. Hysteresis: temp 7 -> 8.
   - State ACTIVE next edge, E=0_1000; temp=10 gives E=0_1010.
   - temp=6 keeps ACTIVE, E=0_0110.
   - temp=4 gives IDLE next edge, E=0.
2. Debounce: bt high 2 cycles then low -> no ALARM, alarm_cnt=0.
   - bt held high -> ALARM on the 4th edge after the first high sample, E=1_0000, alarm_cnt=1.
   - Holding bt longer -> alarm_cnt stays 1.
3. Acknowledge: in ALARM with bt still high, ack=1 -> stays ALARM.
   - bt low for 1 cycle, then ack=1 -> COOLDOWN. E=0 for exactly 4 cycles, then IDLE.
   - temp=9 during COOLDOWN -> no ACTIVE until IDLE is reached, then ACTIVE next edge.
4. Over-temperature: ACTIVE with temp=12, then temp=15 -> ALARM next edge, alarm_cnt increments by 1.
   - temp=15 in COOLDOWN -> ALARM, alarm_cnt increments again.
5. Config error: thr_off=9, thr_on=8 -> cfg_err=1; temp=12 keeps IDLE.
   - Set cfg_err while in ACTIVE -> IDLE next edge.
   - Restore thr_off=5 -> cfg_err=0, ACTIVE next edge.
6. Reset and saturation:
   - 16 alarm cycles -> alarm_cnt saturates at 15.
   - Async reset asserted between edges during COOLDOWN -> state_o=0, E=0, alarm_cnt=0 immediately, before the next clock edge.
